// File: rtl/data_path_if.sv
// Control/data bundle for the data_path register-transfer block: bus-drive selects,
// register load enables, ALU opcode, memory data in, and observation outputs.
interface data_path_if #(
    parameter int DATA_W = 32
);
    logic              Read;
    logic [4:0]        op;
    logic [DATA_W-1:0] Mdatain;

    logic R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out;
    logic R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out;
    logic HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout;

    logic R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in;
    logic R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in;
    logic HIin, Loin, Zhighin, Zlowin, MDRin, InPortin, Yin, InPC;

    logic [DATA_W-1:0] BusOut, mdrData, BusMuxInR0, BusMuxInR1, BusMuxInR2;

    modport master (
        output Read, op, Mdatain,
        output R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
        output R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
        output HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout,
        output R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
        output R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
        output HIin, Loin, Zhighin, Zlowin, MDRin, InPortin, Yin, InPC,
        input  BusOut, mdrData, BusMuxInR0, BusMuxInR1, BusMuxInR2
    );

    modport slave (
        input  Read, op, Mdatain,
        input  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
        input  R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
        input  HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout,
        input  R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
        input  R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
        input  HIin, Loin, Zhighin, Zlowin, MDRin, InPortin, Yin, InPC,
        output BusOut, mdrData, BusMuxInR0, BusMuxInR1, BusMuxInR2
    );
endinterface

// File: rtl/data_path.sv
// Single-bus register file with a combinational ALU (A = Y, B = bus) feeding
// the 64-bit Z register pair; every register clears on a low clear at the clock edge.
module data_path #(
    parameter int DATA_W = 32
) (
    input  logic      Clock,
    input  logic      clear,
    data_path_if.slave dp
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r [16];
    logic [DATA_W-1:0] hi, lo, zhi, zlo, pc, mdr, inport, y;
    logic [DATA_W-1:0] bus_val;
    logic [2*DATA_W-1:0] alu_c;
    logic [15:0] r_out, r_in;

    assign r_out = {dp.R15out, dp.R14out, dp.R13out, dp.R12out, dp.R11out, dp.R10out,
                    dp.R9out, dp.R8out, dp.R7out, dp.R6out, dp.R5out, dp.R4out,
                    dp.R3out, dp.R2out, dp.R1out, dp.R0out};
    assign r_in  = {dp.R15in, dp.R14in, dp.R13in, dp.R12in, dp.R11in, dp.R10in,
                    dp.R9in, dp.R8in, dp.R7in, dp.R6in, dp.R5in, dp.R4in,
                    dp.R3in, dp.R2in, dp.R1in, dp.R0in};

    function automatic logic [2*DATA_W-1:0] alu(
        input logic [4:0]               opc,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [SH_W-1:0]            sh;
        logic [2*DATA_W-1:0]        dbl;
        logic signed [2*DATA_W-1:0] a_ext, b_ext;
        logic [DATA_W-1:0]          lo_w;
        sh    = b[SH_W-1:0];
        dbl   = {a, a};
        a_ext = {{DATA_W{a[DATA_W-1]}}, a};
        b_ext = {{DATA_W{b[DATA_W-1]}}, b};
        lo_w  = '0;
        alu   = '0;
        case (opc)
            5'd3:  lo_w = a + b;
            5'd4:  lo_w = a - b;
            5'd5:  lo_w = a & b;
            5'd6:  lo_w = a | b;
            // Rotates shift a doubled copy so an amount of 0 falls out naturally.
            5'd7:  lo_w = dbl[DATA_W-1:0] >> sh | dbl[DATA_W-1:0] << (DATA_W - int'(sh)) % DATA_W;
            5'd8:  lo_w = dbl[DATA_W-1:0] << sh | dbl[DATA_W-1:0] >> (DATA_W - int'(sh)) % DATA_W;
            5'd9:  lo_w = a >> sh;
            5'd10: lo_w = a >>> sh;
            5'd11: lo_w = a << sh;
            5'd17: lo_w = '0 - b;
            5'd18: lo_w = ~b;
            default: lo_w = '0;
        endcase
        if (opc == 5'd15) begin
            if (b != '0) alu = {a % b, a / b};
        end else if (opc == 5'd16) begin
            alu = a_ext * b_ext;
        end else begin
            alu = {{DATA_W{1'b0}}, lo_w};
        end
    endfunction

    // Bus mux: later assignments override earlier ones, so R0 ends up highest priority.
    always_comb begin
        bus_val = '0;
        if (dp.Yout)      bus_val = y;
        if (dp.InPortout) bus_val = inport;
        if (dp.MDRout)    bus_val = mdr;
        if (dp.PCout)     bus_val = pc;
        if (dp.Zlowout)   bus_val = zlo;
        if (dp.Zhighout)  bus_val = zhi;
        if (dp.LOout)     bus_val = lo;
        if (dp.HIOut)     bus_val = hi;
        for (int i = 15; i >= 0; i--) begin
            if (r_out[i]) bus_val = r[i];
        end
    end

    assign alu_c = alu(dp.op, y, bus_val);

    always_ff @(posedge Clock) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r[i] <= '0;
            hi <= '0; lo <= '0; zhi <= '0; zlo <= '0;
            pc <= '0; mdr <= '0; inport <= '0; y <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_in[i]) r[i] <= bus_val;
            end
            if (dp.HIin)     hi     <= bus_val;
            if (dp.Loin)     lo     <= bus_val;
            if (dp.Yin)      y      <= bus_val;
            if (dp.MDRin)    mdr    <= dp.Read ? dp.Mdatain : bus_val;
            if (dp.InPortin) inport <= dp.Mdatain;
            if (dp.Zhighin)  zhi    <= alu_c[2*DATA_W-1:DATA_W];
            if (dp.Zlowin)   zlo    <= alu_c[DATA_W-1:0];
            if (dp.InPC)     pc     <= pc + 1'b1;
        end
    end

    assign dp.BusOut     = bus_val;
    assign dp.mdrData    = mdr;
    assign dp.BusMuxInR0 = r[0];
    assign dp.BusMuxInR1 = r[1];
    assign dp.BusMuxInR2 = r[2];
endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: reset, register transfers, ALU ops, bus priority,
// simultaneous loads and clear behaviour, each checked against hand-computed values.
module tb_data_path;
    logic Clock = 1'b0;
    logic clear = 1'b1;
    int   total = 0;
    int   bad   = 0;

    data_path_if #(.DATA_W(32)) dp ();
    data_path #(.DATA_W(32)) dut (.Clock(Clock), .clear(clear), .dp(dp.slave));

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        dp.Read = 0; dp.op = 0;
        {dp.R0out, dp.R1out, dp.R2out, dp.R3out, dp.R4out, dp.R5out, dp.R6out, dp.R7out} = '0;
        {dp.R8out, dp.R9out, dp.R10out, dp.R11out, dp.R12out, dp.R13out, dp.R14out, dp.R15out} = '0;
        {dp.HIOut, dp.LOout, dp.Zhighout, dp.Zlowout, dp.PCout, dp.MDRout, dp.InPortout, dp.Yout} = '0;
        {dp.R0in, dp.R1in, dp.R2in, dp.R3in, dp.R4in, dp.R5in, dp.R6in, dp.R7in} = '0;
        {dp.R8in, dp.R9in, dp.R10in, dp.R11in, dp.R12in, dp.R13in, dp.R14in, dp.R15in} = '0;
        {dp.HIin, dp.Loin, dp.Zhighin, dp.Zlowin, dp.MDRin, dp.InPortin, dp.Yin, dp.InPC} = '0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle(); dp.Mdatain = v; dp.Read = 1; dp.MDRin = 1;
        tick(); idle();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        dp.MDRout = 1; dp.Yin = 1;
        tick(); idle();
    endtask

    // Y <= a, bus <= b via MDR, then latch both Z halves for opcode opc.
    task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] opc);
        load_y(a);
        load_mdr(b);
        dp.MDRout = 1; dp.op = opc; dp.Zhighin = 1; dp.Zlowin = 1;
        tick(); idle();
    endtask

    // sel: 0 ZLO, 1 ZHI, 2 PC, 3 Y, 4 HI, 5 LO, 6 InPort
    task automatic read_reg(input int sel, output logic [31:0] v);
        idle();
        case (sel)
            0: dp.Zlowout   = 1;
            1: dp.Zhighout  = 1;
            2: dp.PCout     = 1;
            3: dp.Yout      = 1;
            4: dp.HIOut     = 1;
            5: dp.LOout     = 1;
            default: dp.InPortout = 1;
        endcase
        #1 v = dp.BusOut;
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        clear = 0; tick(); clear = 1;
        #1;
        total++; if (dp.BusOut !== 32'h0) begin bad++; $display("FAIL reset_bus got=%h exp=0", dp.BusOut); end
        total++; if (dp.mdrData !== 32'h0) begin bad++; $display("FAIL reset_mdr got=%h exp=0", dp.mdrData); end
        total++; if ({dp.BusMuxInR0, dp.BusMuxInR1, dp.BusMuxInR2} !== 96'h0) begin
            bad++; $display("FAIL reset_r012 got=%h %h %h exp=0", dp.BusMuxInR0, dp.BusMuxInR1, dp.BusMuxInR2);
        end
        for (int s = 0; s < 7; s++) begin
            read_reg(s, v);
            total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_sel%0d got=%h exp=0", s, v); end
        end
    endtask

    task automatic test_pc();
        logic [31:0] v;
        idle(); dp.InPC = 1;
        repeat (3) tick();
        idle();
        read_reg(2, v);
        total++; if (v !== 32'd3) begin bad++; $display("FAIL pc_inc got=%h exp=3", v); end
    endtask

    task automatic test_and();
        logic [31:0] v;
        load_mdr(32'h12); dp.MDRout = 1; dp.R2in = 1; tick(); idle();
        total++; if (dp.BusMuxInR2 !== 32'h12) begin bad++; $display("FAIL load_r2 got=%h exp=12", dp.BusMuxInR2); end
        total++; if (dp.mdrData !== 32'h12) begin bad++; $display("FAIL mdr_data got=%h exp=12", dp.mdrData); end
        load_mdr(32'h14); dp.MDRout = 1; dp.R3in = 1; tick(); idle();
        dp.R2out = 1; dp.Yin = 1; tick(); idle();
        dp.R3out = 1; dp.op = 5'd5; dp.Zlowin = 1; tick(); idle();
        read_reg(0, v);
        total++; if (v !== 32'h10) begin bad++; $display("FAIL and_zlo got=%h exp=10", v); end
        dp.Zlowout = 1; dp.R1in = 1; tick(); idle();
        total++; if (dp.BusMuxInR1 !== 32'h10) begin bad++; $display("FAIL load_r1 got=%h exp=10", dp.BusMuxInR1); end
    endtask

    task automatic test_alu_misc();
        logic [31:0] lo_v, hi_v;
        logic [4:0]  ops [7]  = '{5'd3, 5'd4, 5'd6, 5'd17, 5'd18, 5'd0, 5'd12};
        logic [31:0] av  [7]  = '{32'd5, 32'd3, 32'hF0, 32'h0, 32'h0, 32'h1234, 32'h1234};
        logic [31:0] bv  [7]  = '{32'd7, 32'd5, 32'h0F, 32'h1, 32'h0, 32'h5678, 32'h5678};
        logic [31:0] ex  [7]  = '{32'd12, 32'hFFFFFFFE, 32'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            alu_run(av[i], bv[i], ops[i]);
            read_reg(0, lo_v); read_reg(1, hi_v);
            total++; if (lo_v !== ex[i] || hi_v !== 32'h0) begin
                bad++; $display("FAIL alu_op%0d got=%h_%h exp=00000000_%h", ops[i], hi_v, lo_v, ex[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] lo_v, hi_v;
        alu_run(32'hFFFFFFFE, 32'd3, 5'd16);
        read_reg(0, lo_v); read_reg(1, hi_v);
        total++; if (hi_v !== 32'hFFFFFFFF) begin bad++; $display("FAIL mul_hi got=%h exp=ffffffff", hi_v); end
        total++; if (lo_v !== 32'hFFFFFFFA) begin bad++; $display("FAIL mul_lo got=%h exp=fffffffa", lo_v); end
    endtask

    task automatic test_div();
        logic [31:0] lo_v, hi_v;
        alu_run(32'd17, 32'd5, 5'd15);
        read_reg(0, lo_v); read_reg(1, hi_v);
        total++; if ({hi_v, lo_v} !== {32'd2, 32'd3}) begin bad++; $display("FAIL div_pos got=%h_%h exp=2_3", hi_v, lo_v); end
        alu_run(32'hFFFFFFF9, 32'd2, 5'd15);
        read_reg(0, lo_v); read_reg(1, hi_v);
        total++; if ({hi_v, lo_v} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
            bad++; $display("FAIL div_neg got=%h_%h exp=ffffffff_fffffffd", hi_v, lo_v);
        end
        alu_run(32'd17, 32'd0, 5'd15);
        read_reg(0, lo_v); read_reg(1, hi_v);
        total++; if ({hi_v, lo_v} !== 64'h0) begin bad++; $display("FAIL div_zero got=%h_%h exp=0_0", hi_v, lo_v); end
    endtask

    task automatic test_shift();
        logic [31:0] lo_v;
        logic [4:0]  ops [5] = '{5'd9, 5'd10, 5'd7, 5'd8, 5'd11};
        logic [31:0] ex  [5] = '{32'h40000000, 32'hC0000000, 32'hC0000000, 32'h00000003, 32'h00000002};
        for (int i = 0; i < 5; i++) begin
            alu_run(32'h80000001, 32'd1, ops[i]);
            read_reg(0, lo_v);
            total++; if (lo_v !== ex[i]) begin bad++; $display("FAIL shift_op%0d got=%h exp=%h", ops[i], lo_v, ex[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            alu_run(32'h80000001, 32'd32, ops[i]);
            read_reg(0, lo_v);
            total++; if (lo_v !== 32'h80000001) begin bad++; $display("FAIL shift0_op%0d got=%h exp=80000001", ops[i], lo_v); end
        end
    endtask

    task automatic test_priority();
        load_mdr(32'hAA); dp.MDRout = 1; dp.R0in = 1; tick(); idle();
        load_mdr(32'hBB); dp.MDRout = 1; dp.R1in = 1; tick(); idle();
        load_mdr(32'hCC); dp.MDRout = 1; dp.HIin = 1; tick(); idle();
        load_y(32'h77);
        dp.Mdatain = 32'h99; dp.InPortin = 1; tick(); idle();
        load_mdr(32'h66);
        dp.R0out = 1; dp.R1out = 1; dp.HIOut = 1; #1;
        total++; if (dp.BusOut !== 32'hAA) begin bad++; $display("FAIL prio_r0 got=%h exp=aa", dp.BusOut); end
        idle(); dp.R1out = 1; dp.HIOut = 1; dp.Yout = 1; #1;
        total++; if (dp.BusOut !== 32'hBB) begin bad++; $display("FAIL prio_r1 got=%h exp=bb", dp.BusOut); end
        idle(); dp.HIOut = 1; dp.PCout = 1; #1;
        total++; if (dp.BusOut !== 32'hCC) begin bad++; $display("FAIL prio_hi got=%h exp=cc", dp.BusOut); end
        idle(); dp.PCout = 1; dp.MDRout = 1; dp.Yout = 1; #1;
        total++; if (dp.BusOut !== 32'd3) begin bad++; $display("FAIL prio_pc got=%h exp=3", dp.BusOut); end
        idle(); dp.MDRout = 1; dp.InPortout = 1; dp.Yout = 1; #1;
        total++; if (dp.BusOut !== 32'h66) begin bad++; $display("FAIL prio_mdr got=%h exp=66", dp.BusOut); end
        idle(); dp.InPortout = 1; dp.Yout = 1; #1;
        total++; if (dp.BusOut !== 32'h99) begin bad++; $display("FAIL prio_inport got=%h exp=99", dp.BusOut); end
        idle(); #1;
        total++; if (dp.BusOut !== 32'h0) begin bad++; $display("FAIL empty_bus got=%h exp=0", dp.BusOut); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        // Bus = R1 (0xBB), Y = 0x77; all loads must see the pre-edge bus and Y.
        idle(); dp.R1out = 1; dp.R2in = 1; dp.Yin = 1; dp.MDRin = 1; dp.Read = 0;
        dp.Mdatain = 32'h1111; dp.op = 5'd3; dp.Zlowin = 1;
        tick(); idle();
        total++; if (dp.BusMuxInR2 !== 32'hBB) begin bad++; $display("FAIL simul_r2 got=%h exp=bb", dp.BusMuxInR2); end
        total++; if (dp.mdrData !== 32'hBB) begin bad++; $display("FAIL simul_mdr got=%h exp=bb", dp.mdrData); end
        read_reg(3, v);
        total++; if (v !== 32'hBB) begin bad++; $display("FAIL simul_y got=%h exp=bb", v); end
        read_reg(0, v);
        total++; if (v !== 32'h132) begin bad++; $display("FAIL simul_zlo got=%h exp=132", v); end
    endtask

    task automatic test_clear();
        logic [31:0] v;
        idle(); dp.InPC = 1; dp.MDRin = 1; dp.Read = 1; dp.Mdatain = 32'h5A;
        clear = 0;
        #2;
        total++; if (dp.BusMuxInR1 !== 32'hBB) begin bad++; $display("FAIL clear_noedge got=%h exp=bb", dp.BusMuxInR1); end
        tick(); clear = 1; idle();
        total++; if ({dp.BusMuxInR0, dp.BusMuxInR1, dp.BusMuxInR2, dp.mdrData} !== 128'h0) begin
            bad++; $display("FAIL clear_regs got=%h %h %h %h exp=0", dp.BusMuxInR0, dp.BusMuxInR1, dp.BusMuxInR2, dp.mdrData);
        end
        for (int s = 0; s < 7; s++) begin
            read_reg(s, v);
            total++; if (v !== 32'h0) begin bad++; $display("FAIL clear_sel%0d got=%h exp=0", s, v); end
        end
    endtask

    initial begin
        idle();
        dp.Mdatain = '0;
        #1;
        test_reset();
        test_pc();
        test_and();
        test_alu_misc();
        test_mul();
        test_div();
        test_shift();
        test_priority();
        test_back_to_back();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
